// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg: shared configuration constants and FSM encoding for the instruction fetch unit
package ifu_fetch_pkg;
  localparam int unsigned IFU_ISA_WIDTH = 32;
  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] IFU_NOP_INST = 32'h0000_0013;
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2,
    S_HALT = 2'd3
  } fetch_state_e;
endpackage

// File: rtl/ifu_pc.sv
// ifu_pc: program counter register with +4 increment, redirect mux and misalignment flag
// Ports: clk/rst (sync, active-low); redirect_valid/redirect_pc load a new pc;
// adv steps pc by 4; pc is the current fetch address; misa marks a misaligned redirect target.
module ifu_pc import ifu_fetch_pkg::*; #(
  parameter int unsigned ISA_WIDTH = IFU_ISA_WIDTH,
  parameter logic [ISA_WIDTH-1:0] RESET_PC = ISA_WIDTH'(IFU_RESET_PC)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 redirect_valid,
  input  logic [ISA_WIDTH-1:0] redirect_pc,
  input  logic                 adv,
  output logic [ISA_WIDTH-1:0] pc,
  output logic                 misa
);
  logic [ISA_WIDTH-1:0] pc_inc;
  assign pc_inc = pc + ISA_WIDTH'(4);
  // misa belongs to the redirect itself; sequential steps after it are fetched normally
  always_ff @(posedge clk)
    if (!rst) begin
      pc   <= RESET_PC;
      misa <= 1'b0;
    end else if (redirect_valid) begin
      pc   <= redirect_pc;
      misa <= |redirect_pc[1:0];
    end else if (adv) begin
      pc   <= pc_inc;
      misa <= 1'b0;
    end
endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: single-outstanding instruction fetch unit with redirect, fault and halt handling
// Ports: clk/rst (sync, active-low); imem_req_* request handshake to instruction memory;
// imem_rsp_* single-cycle response pulse; inst_* buffered instruction to the decoder;
// redirect_valid/redirect_pc control-flow change; halt stops fetching until reset.
module ifu_fetch import ifu_fetch_pkg::*; #(
  parameter int unsigned ISA_WIDTH = IFU_ISA_WIDTH,
  parameter logic [ISA_WIDTH-1:0] RESET_PC = ISA_WIDTH'(IFU_RESET_PC),
  parameter logic [ISA_WIDTH-1:0] NOP_INST = ISA_WIDTH'(IFU_NOP_INST)
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [ISA_WIDTH-1:0] imem_req_addr,
  input  logic                 imem_rsp_valid,
  input  logic [ISA_WIDTH-1:0] imem_rsp_data,
  input  logic                 imem_rsp_err,
  output logic                 inst_valid,
  input  logic                 inst_ready,
  output logic [ISA_WIDTH-1:0] inst,
  output logic [ISA_WIDTH-1:0] inst_pc,
  output logic                 inst_fault,
  input  logic                 redirect_valid,
  input  logic [ISA_WIDTH-1:0] redirect_pc,
  input  logic                 halt
);
  fetch_state_e state_q, state_d;
  logic drop_q, drop_d, halted_q, pc_adv, buf_load, buf_fault, misa;
  logic [ISA_WIDTH-1:0] pc;
  ifu_pc #(.ISA_WIDTH(ISA_WIDTH), .RESET_PC(RESET_PC)) u_pc (
    .clk(clk),
    .rst(rst),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .adv(pc_adv),
    .pc(pc),
    .misa(misa)
  );
  assign imem_req_addr = pc;
  assign inst_valid = rst & (state_q == S_OUT) & ~redirect_valid;
  always_ff @(posedge clk)
    if (!rst) state_q <= S_REQ;
    else state_q <= state_d;
  always_ff @(posedge clk)
    if (!rst) begin
      drop_q     <= 1'b0;
      halted_q   <= 1'b0;
      inst       <= '0;
      inst_fault <= 1'b0;
      inst_pc    <= RESET_PC;
    end else begin
      drop_q   <= drop_d;
      halted_q <= halted_q | halt;
      if (buf_load) begin
        inst       <= buf_fault ? NOP_INST : imem_rsp_data;
        inst_fault <= buf_fault;
        inst_pc    <= pc;
      end
    end
  always_comb begin
    state_d        = state_q;
    drop_d         = drop_q;
    imem_req_valid = 1'b0;
    pc_adv         = 1'b0;
    buf_load       = 1'b0;
    buf_fault      = 1'b0;
    unique case (state_q)
      S_REQ: begin
        // a misaligned redirect target never reaches memory; it is turned into a faulted NOP
        imem_req_valid = rst & ~halted_q & ~halt & ~misa;
        if (halted_q) state_d = S_HALT;
        else if (misa && !redirect_valid) begin
          buf_load  = 1'b1;
          buf_fault = 1'b1;
          pc_adv    = 1'b1;
          state_d   = S_OUT;
        end else if (imem_req_valid && imem_req_ready) begin
          // a request accepted alongside a redirect fetched the old path
          drop_d  = redirect_valid;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) drop_d = 1'b1;
        if (imem_rsp_valid) begin
          if (drop_q || redirect_valid) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            buf_load  = 1'b1;
            buf_fault = imem_rsp_err;
            pc_adv    = 1'b1;
            state_d   = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (redirect_valid) state_d = S_REQ;
        else if (inst_ready) state_d = (halted_q || halt) ? S_HALT : S_REQ;
      end
      S_HALT: state_d = S_HALT;
    endcase
  end
endmodule
